// File: rtl/button_event_ctrl.sv
// Press-event controller: per-button hold-time FSMs turn debounced levels into
// SHORT/LONG/REPEAT/RELEASE events, arbitrated round-robin into a show-ahead FIFO.
module button_event_ctrl #(
    parameter int WIDTH      = 4,
    parameter int TICK_RATE  = 125000,
    parameter int LONG_MS    = 1000,
    parameter int REPEAT_MS  = 200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         btn,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(WIDTH)-1:0] evt_id,
    output logic [1:0]               evt_type,
    output logic                     overflow,
    input  logic                     ovf_clr
);
    localparam int ID_W  = $clog2(WIDTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [23:0] TICK_LAST = 24'(TICK_RATE - 1);
    localparam logic [16:0] LONG_LIM  = 17'(LONG_MS);
    localparam logic [16:0] REP_LIM   = 17'(REPEAT_MS);

    localparam logic [1:0] EV_SHORT   = 2'd0;
    localparam logic [1:0] EV_LONG    = 2'd1;
    localparam logic [1:0] EV_REPEAT  = 2'd2;
    localparam logic [1:0] EV_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        ST_ARM,
        ST_IDLE,
        ST_PRESSED,
        ST_HELD
    } btn_state_e;

    logic [23:0]      tick_cnt_q, tick_cnt_d;
    logic             tick;

    btn_state_e       state_q    [WIDTH];
    btn_state_e       state_d    [WIDTH];
    logic [15:0]      hold_cnt_q [WIDTH];
    logic [15:0]      hold_cnt_d [WIDTH];
    logic [WIDTH-1:0] emit;
    logic [1:0]       emit_type  [WIDTH];

    logic [WIDTH-1:0] slot_vld_q, slot_vld_d;
    logic [1:0]       slot_type_q [WIDTH];
    logic [1:0]       slot_type_d [WIDTH];
    logic             drop;

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             grant_vld;
    logic [ID_W-1:0]  grant_idx;

    logic             overflow_q, overflow_d;

    logic [ID_W+1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic             push, pop, fifo_has_room;
    logic [ID_W+1:0]  head;

    // ---------------- tick generator ----------------
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 24'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // ---------------- per-button hold FSMs ----------------
    // Release is checked before the tick so it always beats a threshold.
    always_comb begin
        logic [16:0] inc;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i]    = state_q[i];
            hold_cnt_d[i] = hold_cnt_q[i];
            emit[i]       = 1'b0;
            emit_type[i]  = EV_SHORT;
            inc           = {1'b0, hold_cnt_q[i]} + 17'd1;
            case (state_q[i])
                ST_ARM: begin
                    if (!btn[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (btn[i]) begin
                        state_d[i]    = ST_PRESSED;
                        hold_cnt_d[i] = '0;
                    end
                end
                ST_PRESSED: begin
                    if (!btn[i]) begin
                        state_d[i]   = ST_IDLE;
                        emit[i]      = 1'b1;
                        emit_type[i] = EV_SHORT;
                    end else if (tick) begin
                        if (inc == LONG_LIM) begin
                            state_d[i]    = ST_HELD;
                            hold_cnt_d[i] = '0;
                            emit[i]       = 1'b1;
                            emit_type[i]  = EV_LONG;
                        end else begin
                            hold_cnt_d[i] = inc[15:0];
                        end
                    end
                end
                ST_HELD: begin
                    if (!btn[i]) begin
                        state_d[i]   = ST_IDLE;
                        emit[i]      = 1'b1;
                        emit_type[i] = EV_RELEASE;
                    end else if (tick) begin
                        if (inc == REP_LIM) begin
                            hold_cnt_d[i] = '0;
                            emit[i]       = 1'b1;
                            emit_type[i]  = EV_REPEAT;
                        end else begin
                            hold_cnt_d[i] = inc[15:0];
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_ARM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i]    <= ST_ARM;
                hold_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i]    <= state_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
            end
        end
    end

    // ---------------- round-robin arbiter ----------------
    always_comb begin
        logic [ID_W-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (fifo_has_room) begin
            for (int k = 1; k <= WIDTH; k++) begin
                cand = ID_W'((int'(rr_ptr_q) + k) % WIDTH);
                if (!grant_vld && slot_vld_q[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        rr_ptr_d = grant_vld ? grant_idx : rr_ptr_q;
    end

    // ---------------- pending slots and overflow ----------------
    // A slot granted this cycle may be refilled by the same cycle's emission.
    always_comb begin
        logic granted;
        drop = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            slot_vld_d[i]  = slot_vld_q[i];
            slot_type_d[i] = slot_type_q[i];
            granted        = grant_vld && (grant_idx == ID_W'(i));
            if (emit[i]) begin
                if (slot_vld_q[i] && !granted) begin
                    drop = 1'b1;
                end else begin
                    slot_vld_d[i]  = 1'b1;
                    slot_type_d[i] = emit_type[i];
                end
            end else if (granted) begin
                slot_vld_d[i] = 1'b0;
            end
        end
        overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld_q <= '0;
            rr_ptr_q   <= ID_W'(WIDTH - 1);
            overflow_q <= 1'b0;
        end else begin
            slot_vld_q <= slot_vld_d;
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            slot_type_q[i] <= slot_type_d[i];
        end
    end

    // ---------------- event FIFO ----------------
    always_comb begin
        fifo_has_room = (fifo_cnt_q < CNT_W'(FIFO_DEPTH));
        push          = grant_vld;
        evt_valid     = (fifo_cnt_q != '0);
        pop           = evt_valid && evt_ready;
        wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {grant_idx, slot_type_q[grant_idx]};
        end
    end

    // Head is forced to zero while empty so reset leaves id/type at 0.
    always_comb begin
        head     = mem_q[rd_ptr_q];
        evt_id   = evt_valid ? head[ID_W+1:2] : '0;
        evt_type = evt_valid ? head[1:0] : '0;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed scenarios with fixed expectations plus a
// randomized run compared cycle by cycle against a queue-based event model.
module tb_button_event_ctrl;
    localparam int WIDTH      = 4;
    localparam int TICK_RATE  = 4;
    localparam int LONG_MS    = 3;
    localparam int REPEAT_MS  = 2;
    localparam int FIFO_DEPTH = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic [WIDTH-1:0] btn       = '0;
    logic             evt_ready = 1'b1;
    logic             ovf_clr   = 1'b0;
    logic             evt_valid;
    logic [1:0]       evt_id;
    logic [1:0]       evt_type;
    logic             overflow;

    int errors = 0;
    int checks = 0;

    button_event_ctrl #(
        .WIDTH(WIDTH), .TICK_RATE(TICK_RATE), .LONG_MS(LONG_MS),
        .REPEAT_MS(REPEAT_MS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_id(evt_id), .evt_type(evt_type),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Behavioural model: each button is described by flags (armed, down, long)
    // and a tick count; queued events are id*4+type in a queue.
    int m_q[$];
    bit m_armed [WIDTH];
    bit m_down  [WIDTH];
    bit m_long  [WIDTH];
    int m_ticks [WIDTH];
    bit m_sv    [WIDTH];
    int m_st    [WIDTH];
    int m_rr;
    bit m_ovf;
    int m_cyc;

    task automatic model_reset();
        m_q.delete();
        m_cyc = 0;
        m_rr  = WIDTH - 1;
        m_ovf = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            m_armed[i] = 1'b0; m_down[i] = 1'b0; m_long[i] = 1'b0;
            m_ticks[i] = 0;    m_sv[i]   = 1'b0; m_st[i]   = 0;
        end
    endtask

    task automatic model_step();
        bit tk;
        bit dropped;
        int g;
        int e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tk = ((m_cyc % TICK_RATE) == TICK_RATE - 1);
        m_cyc++;
        g = -1;
        if (m_q.size() < FIFO_DEPTH) begin
            for (int k = 1; k <= WIDTH; k++) begin
                if (g < 0 && m_sv[(m_rr + k) % WIDTH]) g = (m_rr + k) % WIDTH;
            end
        end
        if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back(g * 4 + m_st[g]);
            m_sv[g] = 1'b0;
            m_rr    = g;
        end
        dropped = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            e = -1;
            if (!m_armed[i]) begin
                if (!btn[i]) m_armed[i] = 1'b1;
            end else if (m_down[i]) begin
                if (!btn[i]) begin
                    e = m_long[i] ? 3 : 0;
                    m_down[i] = 1'b0;
                end else if (tk) begin
                    m_ticks[i]++;
                    if (!m_long[i] && m_ticks[i] == LONG_MS) begin
                        e = 1; m_long[i] = 1'b1; m_ticks[i] = 0;
                    end else if (m_long[i] && m_ticks[i] == REPEAT_MS) begin
                        e = 2; m_ticks[i] = 0;
                    end
                end
            end else if (btn[i]) begin
                m_down[i] = 1'b1; m_long[i] = 1'b0; m_ticks[i] = 0;
            end
            if (e >= 0) begin
                if (m_sv[i]) dropped = 1'b1;
                else begin m_sv[i] = 1'b1; m_st[i] = e; end
            end
        end
        if (dropped) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
    endtask

    task automatic tick_cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) tick_cyc();
    endtask

    task automatic do_reset(input logic [WIDTH-1:0] b);
        btn = b; evt_ready = 1'b1; ovf_clr = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
    endtask

    task automatic wait_valid(input int max, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (n < max && !ok) begin
            tick_cyc();
            n++;
            if (evt_valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        btn = '0; rst_n = 1'b0; model_reset();
        cycles(2);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (evt_id !== 2'd0 || evt_type !== 2'd0) begin errors++; $display("FAIL reset_head: got id=%0d type=%0d want 0/0", evt_id, evt_type); end
        rst_n = 1'b1;
        cycles(3);
        checks++; if (evt_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got valid=%b ovf=%b want 0/0", evt_valid, overflow); end
    endtask

    task automatic test_short();
        int n; bit ok; int cnt;
        do_reset('0);
        btn = 4'b0010; cycles(6); btn = '0;
        wait_valid(10, n, ok);
        checks++; if (!ok || n !== 2) begin errors++; $display("FAIL short_latency: got %0d cycles (seen=%b) want 2", n, ok); end
        checks++; if (evt_id !== 2'd1 || evt_type !== 2'd0) begin errors++; $display("FAIL short_event: got id=%0d type=%0d want 1/0", evt_id, evt_type); end
        cnt = 0;
        repeat (20) begin tick_cyc(); if (evt_valid) cnt++; end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL short_extra: got %0d extra valid cycles want 0", cnt); end
    endtask

    task automatic test_long();
        int ev_cyc [8]; logic [1:0] ev_id [8]; logic [1:0] ev_ty [8];
        int nev; int n; bit ok;
        do_reset('0);
        nev = 0;
        btn = 4'b0100;
        for (int c = 1; c <= 40; c++) begin
            tick_cyc();
            if (evt_valid && nev < 8) begin
                ev_cyc[nev] = c; ev_id[nev] = evt_id; ev_ty[nev] = evt_type; nev++;
            end
        end
        btn = '0;
        checks++; if (nev !== 4) begin errors++; $display("FAIL long_count: got %0d events during hold want 4", nev); end
        if (nev >= 1) begin
            checks++; if (ev_id[0] !== 2'd2 || ev_ty[0] !== 2'd1) begin errors++; $display("FAIL long_first: got id=%0d type=%0d want 2/1", ev_id[0], ev_ty[0]); end
            checks++; if (ev_cyc[0] < 11 || ev_cyc[0] > 14) begin errors++; $display("FAIL long_time: got cycle %0d want 11..14", ev_cyc[0]); end
        end
        for (int k = 1; k < nev && k < 4; k++) begin
            checks++; if (ev_id[k] !== 2'd2 || ev_ty[k] !== 2'd2 || ev_cyc[k] - ev_cyc[k-1] !== 8) begin
                errors++; $display("FAIL long_repeat%0d: got id=%0d type=%0d gap=%0d want 2/2/8", k, ev_id[k], ev_ty[k], ev_cyc[k] - ev_cyc[k-1]);
            end
        end
        wait_valid(10, n, ok);
        checks++; if (!ok || n !== 2 || evt_id !== 2'd2 || evt_type !== 2'd3) begin
            errors++; $display("FAIL long_release: got n=%0d id=%0d type=%0d want 2/2/3", n, evt_id, evt_type);
        end
    endtask

    task automatic test_simultaneous();
        int n; bit ok;
        do_reset('0);
        btn = 4'hF; cycles(3); btn = '0;
        wait_valid(10, n, ok);
        for (int k = 0; k < 4; k++) begin
            checks++; if (evt_valid !== 1'b1 || evt_id !== 2'(k) || evt_type !== 2'd0) begin
                errors++; $display("FAIL simul_order%0d: got valid=%b id=%0d type=%0d want 1/%0d/0", k, evt_valid, evt_id, evt_type, k);
            end
            tick_cyc();
        end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL simul_drain: got valid=%b want 0", evt_valid); end
        btn = 4'b1010; cycles(3); btn = '0;
        wait_valid(10, n, ok);
        checks++; if (!ok || evt_id !== 2'd1) begin errors++; $display("FAIL rr_first: got id=%0d want 1", evt_id); end
        tick_cyc();
        checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin errors++; $display("FAIL rr_second: got valid=%b id=%0d want 1/3", evt_valid, evt_id); end
        tick_cyc();
    endtask

    task automatic test_backpressure();
        int cnt;
        do_reset('0);
        evt_ready = 1'b0;
        repeat (4) begin btn = 4'b0001; cycles(2); btn = '0; cycles(2); end
        cycles(2);
        checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_type !== 2'd0) begin
            errors++; $display("FAIL bp_head: got valid=%b id=%0d type=%0d want 1/0/0", evt_valid, evt_id, evt_type);
        end
        btn = 4'b0001; cycles(2); btn = '0; cycles(3);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_fifth: got overflow=%b want 0", overflow); end
        btn = 4'b0001; cycles(2); btn = '0; cycles(3);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_sixth: got overflow=%b want 1", overflow); end
        evt_ready = 1'b1;
        cnt = 0;
        repeat (15) begin if (evt_valid) cnt++; tick_cyc(); end
        checks++; if (cnt !== 5) begin errors++; $display("FAIL bp_drain: got %0d events want 5", cnt); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_sticky: got overflow=%b want 1", overflow); end
        ovf_clr = 1'b1; tick_cyc(); ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_clear: got overflow=%b want 0", overflow); end
    endtask

    task automatic test_held_reset();
        int cnt; logic [1:0] sid; logic [1:0] sty;
        do_reset(4'b0001);
        cnt = 0;
        repeat (30) begin tick_cyc(); if (evt_valid) cnt++; end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL held_silent: got %0d valid cycles want 0", cnt); end
        btn = '0; cycles(2); btn = 4'b0001; cycles(3); btn = '0;
        cnt = 0; sid = 2'd3; sty = 2'd3;
        repeat (15) begin tick_cyc(); if (evt_valid) begin cnt++; sid = evt_id; sty = evt_type; end end
        checks++; if (cnt !== 1 || sid !== 2'd0 || sty !== 2'd0) begin
            errors++; $display("FAIL held_after: got %0d events last id=%0d type=%0d want 1/0/0", cnt, sid, sty);
        end
    endtask

    task automatic test_reset_midop();
        int cnt;
        do_reset('0);
        evt_ready = 1'b0;
        btn = 4'b0010; cycles(16);
        btn = 4'b0011; cycles(2); btn = 4'b0010; cycles(3);
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL midop_queued: got valid=%b want 1", evt_valid); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (evt_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL midop_async: got valid=%b ovf=%b want 0/0", evt_valid, overflow);
        end
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        btn = '0; evt_ready = 1'b1;
        cnt = 0;
        repeat (20) begin tick_cyc(); if (evt_valid) cnt++; end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL midop_stale: got %0d valid cycles want 0", cnt); end
    endtask

    task automatic test_random();
        int ready_pct;
        do_reset('0);
        for (int ph = 0; ph < 2; ph++) begin
            ready_pct = (ph == 0) ? 75 : 20;
            for (int c = 0; c < 600; c++) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
                end
                evt_ready = ($urandom_range(0, 99) < ready_pct);
                ovf_clr   = ($urandom_range(0, 15) == 0);
                tick_cyc();
                checks++; if (evt_valid !== (m_q.size() != 0)) begin
                    errors++; $display("FAIL rand_valid @%0d: got %b want %b", c, evt_valid, (m_q.size() != 0));
                end
                checks++; if (overflow !== m_ovf) begin
                    errors++; $display("FAIL rand_overflow @%0d: got %b want %b", c, overflow, m_ovf);
                end
                if (m_q.size() != 0) begin
                    checks++; if (evt_id !== 2'(m_q[0] / 4) || evt_type !== 2'(m_q[0] % 4)) begin
                        errors++; $display("FAIL rand_head @%0d: got id=%0d type=%0d want %0d/%0d", c, evt_id, evt_type, m_q[0] / 4, m_q[0] % 4);
                    end
                end
            end
        end
        btn = '0; evt_ready = 1'b1; ovf_clr = 1'b0;
        cycles(4);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_short();
        test_long();
        test_simultaneous();
        test_backpressure();
        test_held_reset();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
